// File: rtl/mixer_pwm.sv
`default_nettype none
// ============================================================================
// Module   : mixer_pwm
// Brief    : Four-channel volume-scaled audio mixer with an 11-bit PWM DAC.
//            Optional sticky clip flag enabled by MIXER_CLIP_DETECT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mixer_pwm (
    input  logic        clk,
    input  logic        rst,
    input  logic        ena,
    input  logic [10:0] ch0_in,
    input  logic [10:0] ch1_in,
    input  logic [10:0] ch2_in,
    input  logic [10:0] ch3_in,
    input  logic [3:0]  vol0,
    input  logic [3:0]  vol1,
    input  logic [3:0]  vol2,
    input  logic [3:0]  vol3,
`ifdef MIXER_CLIP_DETECT_EN
    input  logic        clip_clr,
    output logic        clip,
`endif
    output logic [10:0] mix_out,
    output logic        pwm_out,
    output logic        sample_tick
);

    localparam logic [10:0] c_MID = 11'd1024;
    localparam logic [10:0] c_TOP = 11'd2047;

    logic [10:0] w_ch  [4];
    logic [3:0]  w_vol [4];

    assign w_ch[0]  = ch0_in;
    assign w_ch[1]  = ch1_in;
    assign w_ch[2]  = ch2_in;
    assign w_ch[3]  = ch3_in;
    assign w_vol[0] = vol0;
    assign w_vol[1] = vol1;
    assign w_vol[2] = vol2;
    assign w_vol[3] = vol3;

    // Stage 1: centre each sample on zero and scale by vol/16 (floor).
    generate
        for (genvar g = 0; g < 4; g++) begin : g_stage1
            logic signed [11:0] w_cen;
            logic signed [12:0] r_s1;

            assign w_cen = $signed({1'b0, w_ch[g]}) - 12'sd1024;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_s1 <= '0;
                end else begin
                    r_s1 <= 13'((17'(w_cen) * 17'($signed({1'b0, w_vol[g]}))) >>> 4);
                end
            end
        end
    endgenerate

    // Stage 2: halve the sum to keep headroom, re-bias, saturate.
    logic signed [14:0] w_sum;
    logic signed [14:0] w_mid;
    logic               w_lo;
    logic               w_hi;
    logic [10:0]        w_mix;

    assign w_sum = 15'(g_stage1[0].r_s1) + 15'(g_stage1[1].r_s1)
                 + 15'(g_stage1[2].r_s1) + 15'(g_stage1[3].r_s1);
    assign w_mid = (w_sum >>> 1) + 15'sd1024;
    assign w_lo  = (w_mid < 15'sd0);
    assign w_hi  = (w_mid > 15'sd2047);
    assign w_mix = w_lo ? 11'd0 : (w_hi ? c_TOP : w_mid[10:0]);

    always_ff @(posedge clk) begin
        if (rst) begin
            mix_out <= c_MID;
        end else begin
            mix_out <= w_mix;
        end
    end

`ifdef MIXER_CLIP_DETECT_EN
    // Setting has priority so a clamp coinciding with a clear is not lost.
    always_ff @(posedge clk) begin
        if (rst) begin
            clip <= 1'b0;
        end else if (w_lo || w_hi) begin
            clip <= 1'b1;
        end else if (clip_clr) begin
            clip <= 1'b0;
        end
    end
`endif

    // PWM stage: duty is only sampled at the period boundary (or while idle).
    logic [10:0] r_cnt;
    logic [10:0] r_duty;
    logic        r_tick;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_duty <= c_MID;
            r_tick <= 1'b0;
        end else if (!ena) begin
            r_cnt  <= '0;
            r_duty <= mix_out;
            r_tick <= 1'b0;
        end else begin
            r_cnt  <= r_cnt + 11'd1;
            r_tick <= (r_cnt == c_TOP);
            if (r_cnt == c_TOP) begin
                r_duty <= mix_out;
            end
        end
    end

    // Gated combinationally so disabling or resetting silences the DAC at once.
    assign pwm_out     = ena & ~rst & (r_cnt < r_duty);
    assign sample_tick = r_tick & ena;

endmodule
`default_nettype wire
